ltm_3wire_slave: RTL
====================

# ltm_3wire_slave

Responder end of the LTM panel 3-wire configuration bus. It oversamples SCEN, SCLK and SDA in the system clock domain and decodes 16-bit frames into writes or reads of a 64×8 register file. For reads it drives SDA back onto the bus. It serves as an in-FPGA panel-register emulator and as the bus-functional counterpart for verifying the 3-wire writer that configures the panel at reset.

## Interface

**Parameters**
- `ADDR_W`, 6: register address width; the register file depth is 2^ADDR_W.
- `DATA_W`, 8: register data width.
- `SYNC_STAGES`, 2: flip-flop stages on each asynchronous bus input (minimum 2).

**Ports**
- `iCLK` in 1: system clock, 50 MHz.
- `iRST` in 1: reset, synchronous, active-high.
- `i3WIRE_SCLK` in 1: bus clock, asynchronous, idle high.
- `i3WIRE_SCEN` in 1: frame enable, asynchronous, active-low.
- `i3WIRE_SDAT` in 1: bus data from the initiator.
- `o3WIRE_SDAT` out 1: read data to the bus.
- `o3WIRE_SDAT_OE` out 1: tri-state enable for `o3WIRE_SDAT`; the top level builds the inout.
- `oREG_WE` out 1: one-cycle pulse when a write commits.
- `oREG_ADDR` out ADDR_W: address of the last decoded frame.
- `oREG_WDATA` out DATA_W: data of the last committed write.
- `oFRAME_ERR` out 1: one-cycle pulse when a frame aborts.
- `oBUSY` out 1: high while a frame is in progress (SCEN low).
- `iDBG_ADDR` in ADDR_W: register file debug read address.
- `oDBG_DATA` out DATA_W: registered debug read data.

## Operation

**Frame format.** 16 bits, MSB first, sampled on SCLK rising edges:
- bits 0–5: address A5..A0
- bit 6: R/W (0 = write, 1 = read)
- bit 7: turnaround, value ignored
- bits 8–15: data D7..D0

**Edge detection.**
- All three inputs pass through `SYNC_STAGES` flip-flops.
- Rise/fall detection compares the last synchronized sample with the previous one.
- An SCLK rising edge counts only if synchronized SCEN was already low in the previous cycle. An edge coinciding with the SCEN fall is ignored.

**State machine.** States: IDLE, ADDR, RW, TA, DATA, HOLD.
- IDLE → ADDR on SCEN fall; the bit counter clears to 0.
- ADDR → RW after 6 counted bits.
- RW → TA after 1 bit; the R/W bit is latched.
- TA → DATA after 1 bit.
- DATA → HOLD after 8 bits.
- HOLD → IDLE on SCEN rise.
- Any non-IDLE state → IDLE on SCEN rise. If fewer than 16 bits were counted, `oFRAME_ERR` pulses, no write occurs and the register file is unchanged.

**Write.** On the 16th counted edge:
- `oREG_WE` pulses.
- `regs[addr]`, `oREG_ADDR` and `oREG_WDATA` update on that same iCLK edge.

**Read.**
- On the SCLK falling edge after the TA bit, assert `o3WIRE_SDAT_OE` and present `regs[addr][7]`.
- On each following SCLK falling edge, shift out the next bit.
- Deassert `o3WIRE_SDAT_OE` on the falling edge after bit 15, or on an SCEN rise, whichever comes first.
- The read data is snapshotted into a shift register at the TA falling edge.

**HOLD behaviour.** Extra SCLK edges in HOLD are ignored. No second write occurs; there is no auto-increment.

**Register file.** Every entry resets to 0.

## Timing

- **Input latency.** An input change is visible to the FSM `SYNC_STAGES` + 1 iCLK cycles after the pin changes.
- **Bus clock limit.** Required SCLK high and low times are each ≥ `SYNC_STAGES` + 2 iCLK cycles. Faster SCLK is unsupported and need not be detected.
- **Reset values.** All outputs are 0 during and after reset, including `o3WIRE_SDAT_OE` and `oDBG_DATA`.
- **Reset mid-frame.** The FSM returns to IDLE and OE drops in the same cycle. No `oFRAME_ERR` pulse is generated. The next frame starts only at a fresh SCEN fall.
- **`oREG_WE`.** Asserted exactly one iCLK cycle per completed write frame.
- **`oBUSY`.** Equals the delayed synchronized SCEN low.
- **Debug port.** `oDBG_DATA` is `regs[iDBG_ADDR]` registered, one cycle of latency. If a write commits to the same address in that cycle, the old value is returned.
- **Read-during-write ordering.** A read frame that immediately follows a write to the same address returns the new value, because the write commits before the next SCEN fall.

## Structure

- **Package `ltm_3wire_pkg`** contains:
  - the FSM state enum;
  - the frame bit-position constants `ADDR_BITS=6`, `RW_POS=6`, `TA_POS=7`, `DATA_POS=8`, `FRAME_BITS=16`.
- **Sub-module `sync_edge_det`**: a parameterised synchronizer that outputs the synchronized level plus rise and fall pulses. It is instantiated three times.
- **Inline in the top module:** the FSM, the 4-bit counter, the shift registers and the register file.

## Test plan

- **Write.** Frame addr=0x03, W, data=0xA5 → one `oREG_WE` pulse; `oREG_ADDR`=0x03; `oREG_WDATA`=0xA5; `oDBG_DATA`@0x03 = 0xA5.
- **Read.** After the write above, read frame addr=0x03 → SDA shows 1,0,1,0,0,1,0,1 on bits 8–15; OE high only during those bits; no `oREG_WE`.
- **Abort.** SCEN rises after 10 bits of a write of 0x5A to 0x07 → one `oFRAME_ERR` pulse; `regs[0x07]` stays 0x00; the next full frame decodes correctly.
- **Extra clocks.** 20 SCLK cycles within one SCEN-low window writing 0x3C to 0x3F → exactly one write; value 0x3C; no error pulse.
- **Reset mid-frame.** `iRST` asserted during a read after bit 10 → OE=0 in the same cycle; all outputs 0; the register file cleared.
- **Back-to-back frames.** Two frames with SCEN high for the minimum 3 cycles between them, writing 0x11→0x01 then 0x22→0x02 → two `oREG_WE` pulses; both registers are correct.

Source files
------------

// File: rtl/ltm_3wire_pkg.sv
// Shared types and frame layout for the LTM 3-wire configuration responder.
package ltm_3wire_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RW,
    S_TA,
    S_DATA,
    S_HOLD
  } state_t;

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned ADDR_BITS  = 6;
  localparam int unsigned RW_POS     = 6;
  localparam int unsigned TA_POS     = 7;
  localparam int unsigned DATA_POS   = 8;
  localparam int unsigned FRAME_BITS = 16;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchronizer for one asynchronous pin with rise/fall pulses.
module sync_edge_det #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] chain;
  logic              prev;
  logic [STAGES:0]   fill;

  // fill masks edges while reset values are still flushing out of the chain
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
      fill  <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
      fill  <= {fill[STAGES-1:0], 1'b1};
    end
  end

  assign level  = chain[STAGES-1];
  assign rise_c = fill[STAGES] & level & ~prev;
  assign fall_c = fill[STAGES] & ~level & prev;

endmodule

// File: rtl/ltm_3wire_slave.sv
// LTM panel 3-wire bus responder: decodes 16-bit frames into writes/reads
// of an internal register file and drives read data back onto SDA.
module ltm_3wire_slave
  import ltm_3wire_pkg::*;
#(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              i3WIRE_SCLK,
  input  logic              i3WIRE_SCEN,
  input  logic              i3WIRE_SDAT,
  output logic              o3WIRE_SDAT,
  output logic              o3WIRE_SDAT_OE,
  output logic              oREG_WE,
  output logic [ADDR_W-1:0] oREG_ADDR,
  output logic [DATA_W-1:0] oREG_WDATA,
  output logic              oFRAME_ERR,
  output logic              oBUSY,
  input  logic [ADDR_W-1:0] iDBG_ADDR,
  output logic [DATA_W-1:0] oDBG_DATA
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic scen, scen_rise, scen_fall;
  logic sclk_rise, sclk_fall, sdat;
  logic unused_sclk_level, unused_sdat_rise, unused_sdat_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scen (
    .clk(iCLK), .rst(iRST), .d(i3WIRE_SCEN),
    .level(scen), .rise_c(scen_rise), .fall_c(scen_fall)
  );
  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
    .clk(iCLK), .rst(iRST), .d(i3WIRE_SCLK),
    .level(unused_sclk_level), .rise_c(sclk_rise), .fall_c(sclk_fall)
  );
  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdat (
    .clk(iCLK), .rst(iRST), .d(i3WIRE_SDAT),
    .level(sdat), .rise_c(unused_sdat_rise), .fall_c(unused_sdat_fall)
  );

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_sr, reg_addr;
  logic [DATA_W-1:0]  data_sr, rd_sr, reg_wdata, dbg_data;
  logic [DATA_W-1:0]  regs [DEPTH];
  logic               rw, busy, sdo, oe, reg_we, frame_err;
  logic               bit_c, commit_c, err_c;
  logic [DATA_W-1:0]  wdata_c;

  // busy is SCEN low as seen one cycle earlier, so an SCLK edge that lands
  // together with the SCEN fall is not counted
  assign bit_c   = sclk_rise & busy;
  assign wdata_c = {data_sr[DATA_W-2:0], sdat};

  always_ff @(posedge iCLK) begin
    if (iRST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit_c  = 1'b0;
    err_c     = 1'b0;
    case (state)
      S_IDLE: if (scen_fall) state_nxt = S_ADDR;
      S_ADDR: if (bit_c && cnt == CNT_W'(ADDR_BITS - 1)) state_nxt = S_RW;
      S_RW:   if (bit_c && cnt == CNT_W'(RW_POS)) state_nxt = S_TA;
      S_TA:   if (bit_c && cnt == CNT_W'(TA_POS)) state_nxt = S_DATA;
      S_DATA: if (bit_c && cnt == CNT_W'(FRAME_BITS - 1)) begin
        state_nxt = S_HOLD;
        commit_c  = ~rw;
      end
      S_HOLD: state_nxt = S_HOLD;
      default: state_nxt = S_IDLE;
    endcase
    if (state != S_IDLE && scen_rise) begin
      state_nxt = S_IDLE;
      commit_c  = 1'b0;
      err_c     = (state != S_HOLD);
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt       <= '0;
      addr_sr   <= '0;
      data_sr   <= '0;
      rd_sr     <= '0;
      rw        <= 1'b0;
      busy      <= 1'b0;
      sdo       <= 1'b0;
      oe        <= 1'b0;
      reg_we    <= 1'b0;
      frame_err <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      dbg_data  <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      busy      <= ~scen;
      reg_we    <= commit_c;
      frame_err <= err_c;
      dbg_data  <= regs[iDBG_ADDR];

      if (state == S_IDLE && scen_fall) cnt <= '0;
      else if (bit_c && state != S_IDLE && state != S_HOLD) cnt <= cnt + CNT_W'(1);

      if (bit_c && state == S_ADDR) addr_sr <= {addr_sr[ADDR_W-2:0], sdat};
      if (bit_c && state == S_RW)   rw      <= sdat;
      if (bit_c && state == S_DATA) data_sr <= wdata_c;

      if (commit_c) begin
        regs[addr_sr] <= wdata_c;
        reg_addr      <= addr_sr;
        reg_wdata     <= wdata_c;
      end

      // read data leaves on SCLK falls; snapshot taken on the fall after TA
      if (state == S_DATA && sclk_fall && busy && rw) begin
        if (cnt == CNT_W'(DATA_POS)) begin
          sdo      <= regs[addr_sr][DATA_W-1];
          rd_sr    <= regs[addr_sr] << 1;
          oe       <= 1'b1;
          reg_addr <= addr_sr;
        end else begin
          sdo   <= rd_sr[DATA_W-1];
          rd_sr <= rd_sr << 1;
        end
      end
      if ((state == S_HOLD && sclk_fall && busy) || scen_rise) begin
        oe  <= 1'b0;
        sdo <= 1'b0;
      end
    end
  end

  assign o3WIRE_SDAT    = sdo;
  assign o3WIRE_SDAT_OE = oe;
  assign oREG_WE        = reg_we;
  assign oREG_ADDR      = reg_addr;
  assign oREG_WDATA     = reg_wdata;
  assign oFRAME_ERR     = frame_err;
  assign oBUSY          = busy;
  assign oDBG_DATA      = dbg_data;

endmodule
